// File: rtl/riscv_memory_mp_v1.sv
// Shared word-addressed memory serving N_PORTS round-robin arbitrated requestors, with
// byte-strobe writes (cap tag follows lane 3), out-of-range errors and a tag-map read port.
module riscv_memory_mp_v1 #(
  parameter int unsigned N_PORTS    = 2,
  parameter int unsigned DATA_WIDTH = 33,
  parameter int unsigned DEPTH      = 'h4000,
  parameter int unsigned AW         = 32,
  parameter int unsigned OUT_REG    = 1,
  parameter string       INIT_FILE  = ""
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic [N_PORTS-1:0]            req_i,
  input  logic [N_PORTS*AW-1:0]         addr_i,
  input  logic [N_PORTS-1:0]            we_i,
  input  logic [N_PORTS*4-1:0]          be_i,
  input  logic [N_PORTS*DATA_WIDTH-1:0] wdata_i,
  output logic [N_PORTS-1:0]            gnt_o,
  output logic [N_PORTS-1:0]            rvalid_o,
  output logic [N_PORTS*DATA_WIDTH-1:0] rdata_o,
  output logic [N_PORTS-1:0]            err_o,
  input  logic                          tsmap_cs_i,
  input  logic [15:0]                   tsmap_addr_i,
  output logic [DATA_WIDTH-1:0]         tsmap_rdata_o
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned PW   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  logic [DATA_WIDTH-1:0]         r_mem [DEPTH];
  logic [PW-1:0]                 r_rr_ptr;
  logic [N_PORTS-1:0]            r_rvalid;
  logic [N_PORTS-1:0]            r_err;
  logic [N_PORTS*DATA_WIDTH-1:0] r_rdata;
  logic [DATA_WIDTH-1:0]         r_tsmap_rdata;

  logic                  w_any;
  logic                  w_xfer;
  logic [PW-1:0]         w_gnt_idx;
  logic [N_PORTS-1:0]    w_gnt;
  logic [AW-1:0]         w_addr;
  logic                  w_we;
  logic [3:0]            w_be;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_mask;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic [IdxW-1:0]       w_idx;
  logic                  w_oor;
  logic                  w_src_valid;
  logic [PW-1:0]         w_src_port;
  logic                  w_src_err;
  logic [DATA_WIDTH-1:0] w_src_data;
  logic [DATA_WIDTH-1:0] w_new_data;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] base, input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    return PW'(s % N_PORTS);
  endfunction

  always_comb begin
    w_any     = 1'b0;
    w_gnt_idx = r_rr_ptr;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      if (!w_any && req_i[wrap_inc(r_rr_ptr, i)]) begin
        w_any     = 1'b1;
        w_gnt_idx = wrap_inc(r_rr_ptr, i);
      end
    end
  end

  // Grants are suppressed while reset is held so nothing transfers or writes.
  assign w_xfer = w_any & rstn_i;

  always_comb begin
    w_gnt            = '0;
    w_gnt[w_gnt_idx] = w_xfer;
  end
  assign gnt_o = w_gnt;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_rr_ptr <= '0;
    end else if (w_xfer) begin
      r_rr_ptr <= wrap_inc(w_gnt_idx, 1);
    end
  end

  assign w_addr  = addr_i[32'(w_gnt_idx)*AW +: AW];
  assign w_we    = we_i[w_gnt_idx];
  assign w_be    = be_i[32'(w_gnt_idx)*4 +: 4];
  assign w_wdata = wdata_i[32'(w_gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign w_idx   = IdxW'(w_addr >> 2);
  assign w_oor   = (w_addr >> (IdxW + 2)) != '0;

  always_comb begin
    w_mask = '0;
    for (int k = 0; k < 4; k++) begin
      w_mask[8*k +: 8] = {8{w_be[k]}};
    end
    if (DATA_WIDTH > 32) begin
      w_mask[DATA_WIDTH-1] = w_be[3];
    end
  end

  assign w_rd_word  = r_mem[w_idx];
  assign w_new_data = (w_we || w_oor) ? '0 : w_rd_word;

  always_ff @(posedge clk_i) begin
    if (w_xfer && w_we && !w_oor) begin
      r_mem[w_idx] <= (w_rd_word & ~w_mask) | (w_wdata & w_mask);
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic                  r_s1_valid;
    logic [PW-1:0]         r_s1_port;
    logic                  r_s1_err;
    logic [DATA_WIDTH-1:0] r_s1_data;

    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        r_s1_valid <= 1'b0;
        r_s1_port  <= '0;
        r_s1_err   <= 1'b0;
        r_s1_data  <= '0;
      end else begin
        r_s1_valid <= w_xfer;
        r_s1_port  <= w_gnt_idx;
        r_s1_err   <= w_oor;
        r_s1_data  <= w_new_data;
      end
    end

    assign w_src_valid = r_s1_valid;
    assign w_src_port  = r_s1_port;
    assign w_src_err   = r_s1_err;
    assign w_src_data  = r_s1_data;
  end else begin : g_no_out_reg
    assign w_src_valid = w_xfer;
    assign w_src_port  = w_gnt_idx;
    assign w_src_err   = w_oor;
    assign w_src_data  = w_new_data;
  end

  // Per-port read data only changes on that port's own response.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_rvalid <= '0;
      r_err    <= '0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= '0;
      if (w_src_valid) begin
        r_rvalid[w_src_port]                                 <= 1'b1;
        r_err[w_src_port]                                    <= w_src_err;
        r_rdata[32'(w_src_port)*DATA_WIDTH +: DATA_WIDTH] <= w_src_data;
      end
    end
  end

  assign rvalid_o = r_rvalid;
  assign err_o    = r_err & r_rvalid;
  assign rdata_o  = r_rdata;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_tsmap_rdata <= '0;
    end else if (tsmap_cs_i) begin
      r_tsmap_rdata <= r_mem[IdxW'(tsmap_addr_i)];
    end
  end
  assign tsmap_rdata_o = r_tsmap_rdata;

endmodule
